// File: rtl/control_unit_if.sv
// Control/status bundle between the hardwired sequencer and the single-bus datapath.
// The master side is the sequencer; the slave side is the datapath (or a bench driving IR/CON/Stop).
interface control_unit_if;
    logic [31:0] IR;
    logic        CON;
    logic        Stop;

    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLOout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
    logic Run;

    modport master (
        input  IR, CON, Stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLOout,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Run
    );

    modport slave (
        output IR, CON, Stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, ZLOout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Run
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch, per-opcode execute steps, END/HALT.
// Strobes decode from the state register alone; CON only gates PCin in the last branch step.
module control_unit (
    input  logic          Clock,
    input  logic          Reset,
    control_unit_if.master bus
);
    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);

    typedef enum logic [4:0] {
        S_RST, S_F0, S_F1, S_F2,
        S_LD0, S_LD1, S_LD2, S_LD3, S_LD4,
        S_LDI0, S_LDI1, S_LDI2,
        S_ST0, S_ST1, S_ST2, S_ST3, S_ST4,
        S_ALU0, S_ALU1, S_ALU2,
        S_ADDI0, S_ADDI1, S_ADDI2,
        S_BR0, S_BR1, S_BR2, S_BR3,
        S_END, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [OP_W-1:0] opcode;
    logic            unused_ir;

    assign opcode    = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_RST;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bus.PCout  = 1'b0;
        bus.PCin   = 1'b0;
        bus.IncPC  = 1'b0;
        bus.MARin  = 1'b0;
        bus.MDRin  = 1'b0;
        bus.MDRout = 1'b0;
        bus.Read   = 1'b0;
        bus.Write  = 1'b0;
        bus.IRin   = 1'b0;
        bus.Yin    = 1'b0;
        bus.Zin    = 1'b0;
        bus.ZLOout = 1'b0;
        bus.Gra    = 1'b0;
        bus.Grb    = 1'b0;
        bus.Grc    = 1'b0;
        bus.Rin    = 1'b0;
        bus.Rout   = 1'b0;
        bus.BAout  = 1'b0;
        bus.Cout   = 1'b0;
        bus.CONin  = 1'b0;
        bus.Run    = 1'b1;

        unique case (state)
            S_RST: begin
                bus.Run   = 1'b0;
                state_nxt = S_F0;
            end
            S_F0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                state_nxt = S_F1;
            end
            S_F1: begin
                bus.ZLOout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                state_nxt = S_F2;
            end
            S_F2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                // Decode uses the IR value present at the edge that leaves F2
                case (opcode)
                    OP_LD:                         state_nxt = S_LD0;
                    OP_LDI:                        state_nxt = S_LDI0;
                    OP_ST:                         state_nxt = S_ST0;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = S_ALU0;
                    OP_ADDI:                       state_nxt = S_ADDI0;
                    OP_BR:                         state_nxt = S_BR0;
                    OP_HALT:                       state_nxt = S_HALT;
                    default:                       state_nxt = S_END;
                endcase
            end

            // Effective-address prefix shared in shape by ld/ldi/st
            S_LD0, S_LDI0, S_ST0: begin
                bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                state_nxt = (state == S_LD0) ? S_LD1 : (state == S_LDI0) ? S_LDI1 : S_ST1;
            end
            S_LD1, S_LDI1, S_ST1: begin
                bus.Cout = 1'b1; bus.Zin = 1'b1;
                state_nxt = (state == S_LD1) ? S_LD2 : (state == S_LDI1) ? S_LDI2 : S_ST2;
            end
            S_LD2, S_ST2: begin
                bus.ZLOout = 1'b1; bus.MARin = 1'b1;
                state_nxt = (state == S_LD2) ? S_LD3 : S_ST3;
            end
            S_LD3: begin
                bus.Read = 1'b1; bus.MDRin = 1'b1;
                state_nxt = S_LD4;
            end
            S_LD4: begin
                bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                state_nxt = S_END;
            end
            S_ST3: begin
                bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                state_nxt = S_ST4;
            end
            S_ST4: begin
                bus.Write = 1'b1;
                state_nxt = S_END;
            end

            S_ALU0, S_ADDI0: begin
                bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                state_nxt = (state == S_ALU0) ? S_ALU1 : S_ADDI1;
            end
            S_ALU1: begin
                bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                state_nxt = S_ALU2;
            end
            S_ADDI1: begin
                bus.Cout = 1'b1; bus.Zin = 1'b1;
                state_nxt = S_ADDI2;
            end
            S_LDI2, S_ALU2, S_ADDI2: begin
                bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                state_nxt = S_END;
            end

            S_BR0: begin
                bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                state_nxt = S_BR1;
            end
            S_BR1: begin
                bus.PCout = 1'b1; bus.Yin = 1'b1;
                state_nxt = S_BR2;
            end
            S_BR2: begin
                bus.Cout = 1'b1; bus.Zin = 1'b1;
                state_nxt = S_BR3;
            end
            S_BR3: begin
                bus.ZLOout = 1'b1; bus.PCin = bus.CON;
                state_nxt = S_END;
            end

            S_END: begin
                state_nxt = bus.Stop ? S_HALT : S_F0;
            end
            S_HALT: begin
                bus.Run   = 1'b0;
                state_nxt = S_HALT;
            end
            default: begin
                bus.Run   = 1'b0;
                state_nxt = S_RST;
            end
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, hand-written corner sequences,
// and randomized instruction streams checked against a step-list model.
module tb_control_unit;
    logic Clock = 1'b0;
    logic Reset;

    control_unit_if bus();

    control_unit dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    // Strobe vector: bit 20 PCout ... bit 0 Run
    localparam logic [20:0] M_PCOUT  = 21'(1) << 20;
    localparam logic [20:0] M_PCIN   = 21'(1) << 19;
    localparam logic [20:0] M_INCPC  = 21'(1) << 18;
    localparam logic [20:0] M_MARIN  = 21'(1) << 17;
    localparam logic [20:0] M_MDRIN  = 21'(1) << 16;
    localparam logic [20:0] M_MDROUT = 21'(1) << 15;
    localparam logic [20:0] M_READ   = 21'(1) << 14;
    localparam logic [20:0] M_WRITE  = 21'(1) << 13;
    localparam logic [20:0] M_IRIN   = 21'(1) << 12;
    localparam logic [20:0] M_YIN    = 21'(1) << 11;
    localparam logic [20:0] M_ZIN    = 21'(1) << 10;
    localparam logic [20:0] M_ZLOOUT = 21'(1) << 9;
    localparam logic [20:0] M_GRA    = 21'(1) << 8;
    localparam logic [20:0] M_GRB    = 21'(1) << 7;
    localparam logic [20:0] M_GRC    = 21'(1) << 6;
    localparam logic [20:0] M_RIN    = 21'(1) << 5;
    localparam logic [20:0] M_ROUT   = 21'(1) << 4;
    localparam logic [20:0] M_BAOUT  = 21'(1) << 3;
    localparam logic [20:0] M_COUT   = 21'(1) << 2;
    localparam logic [20:0] M_CONIN  = 21'(1) << 1;
    localparam logic [20:0] M_RUN    = 21'(1);

    localparam logic [20:0] X_F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
    localparam logic [20:0] X_F1 = M_ZLOOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [20:0] X_F2 = M_MDROUT | M_IRIN | M_RUN;

    logic [20:0] obs;
    assign obs = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                  bus.Read, bus.Write, bus.IRin, bus.Yin, bus.Zin, bus.ZLOout,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout,
                  bus.CONin, bus.Run};

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q[$];
    logic        model_halt;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        int          len;
        logic [20:0] last_exec;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [20:0] act, input logic [20:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %06h expected %06h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Structural rules: at most one register-select, never Read with Write
    task automatic check_rules(input string name);
        total++;
        if ((int'(bus.Gra) + int'(bus.Grb) + int'(bus.Grc)) > 1 || (bus.Read && bus.Write)) begin
            bad++;
            $display("FAIL %s rules: got %06h", name, obs);
        end
    endtask

    // Expected per-cycle strobes for one instruction, F0 through END (or F2 for halt)
    function automatic void build(input logic [4:0] op, input logic con);
        exp_q.delete();
        model_halt = 1'b0;
        exp_q.push_back(X_F0);
        exp_q.push_back(X_F1);
        exp_q.push_back(X_F2);
        case (op)
            5'd0: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN | M_RUN);
                exp_q.push_back(M_COUT | M_ZIN | M_RUN);
                exp_q.push_back(M_ZLOOUT | M_MARIN | M_RUN);
                exp_q.push_back(M_READ | M_MDRIN | M_RUN);
                exp_q.push_back(M_MDROUT | M_GRA | M_RIN | M_RUN);
            end
            5'd1: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN | M_RUN);
                exp_q.push_back(M_COUT | M_ZIN | M_RUN);
                exp_q.push_back(M_ZLOOUT | M_GRA | M_RIN | M_RUN);
            end
            5'd2: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN | M_RUN);
                exp_q.push_back(M_COUT | M_ZIN | M_RUN);
                exp_q.push_back(M_ZLOOUT | M_MARIN | M_RUN);
                exp_q.push_back(M_GRA | M_ROUT | M_MDRIN | M_RUN);
                exp_q.push_back(M_WRITE | M_RUN);
            end
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
                exp_q.push_back(M_GRC | M_ROUT | M_ZIN | M_RUN);
                exp_q.push_back(M_ZLOOUT | M_GRA | M_RIN | M_RUN);
            end
            5'd12: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN | M_RUN);
                exp_q.push_back(M_COUT | M_ZIN | M_RUN);
                exp_q.push_back(M_ZLOOUT | M_GRA | M_RIN | M_RUN);
            end
            5'd18: begin
                exp_q.push_back(M_GRA | M_ROUT | M_CONIN | M_RUN);
                exp_q.push_back(M_PCOUT | M_YIN | M_RUN);
                exp_q.push_back(M_COUT | M_ZIN | M_RUN);
                exp_q.push_back(M_ZLOOUT | (con ? M_PCIN : 21'(0)) | M_RUN);
            end
            5'd27: model_halt = 1'b1;
            default: ;
        endcase
        if (!model_halt) exp_q.push_back(M_RUN);
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_state", 0, obs, 21'(0));
        Reset = 1'b0;
        @(negedge Clock);
        check("first_f0", 0, obs, X_F0);
    endtask

    // Entered with F0 visible; leaves with the next F0 (or HALT) visible.
    // stop_mode: 0 never, 1 held high from F1, 2 random per cycle (IR also scrambled off the decode edge)
    task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_mode,
                             input string tag, output logic halted);
        int   n;
        logic st;
        logic last_stop;
        build(ir[31:27], con);
        n = exp_q.size();
        bus.CON   = con;
        last_stop = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clock);
            check(tag, i, obs, exp_q[i]);
            check_rules(tag);
            bus.IR = (i == 2 || stop_mode != 2) ? ir : $urandom;
            case (stop_mode)
                0:       st = 1'b0;
                1:       st = 1'b1;
                default: st = ($urandom_range(0, 5) == 0);
            endcase
            bus.Stop  = st;
            last_stop = st;
        end
        halted = model_halt || last_stop;
        @(negedge Clock);
        check({tag, "_next"}, n, obs, halted ? 21'(0) : X_F0);
        bus.Stop = 1'b0;
    endtask

    vec_t vecs[12];
    logic halted;
    logic [4:0] known_ops[10];

    initial begin
        Reset    = 1'b1;
        bus.IR   = 32'h0;
        bus.CON  = 1'b0;
        bus.Stop = 1'b0;

        vecs[0]  = '{32'h00800075, 1'b0, 9, M_MDROUT | M_GRA | M_RIN | M_RUN};
        vecs[1]  = '{32'h08000000, 1'b0, 7, M_ZLOOUT | M_GRA | M_RIN | M_RUN};
        vecs[2]  = '{32'h10000000, 1'b0, 9, M_WRITE | M_RUN};
        vecs[3]  = '{32'h18000000, 1'b0, 7, M_ZLOOUT | M_GRA | M_RIN | M_RUN};
        vecs[4]  = '{32'h20000000, 1'b1, 7, M_ZLOOUT | M_GRA | M_RIN | M_RUN};
        vecs[5]  = '{32'h28000000, 1'b0, 7, M_ZLOOUT | M_GRA | M_RIN | M_RUN};
        vecs[6]  = '{32'h30000000, 1'b0, 7, M_ZLOOUT | M_GRA | M_RIN | M_RUN};
        vecs[7]  = '{32'h60000000, 1'b0, 7, M_ZLOOUT | M_GRA | M_RIN | M_RUN};
        vecs[8]  = '{32'h90000010, 1'b1, 8, M_ZLOOUT | M_PCIN | M_RUN};
        vecs[9]  = '{32'h90000010, 1'b0, 8, M_ZLOOUT | M_RUN};
        vecs[10] = '{32'hF8000000, 1'b0, 4, X_F2};
        vecs[11] = '{32'h38000000, 1'b1, 4, X_F2};

        known_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd27};

        do_reset();

        // Reset mid-F1: strobes drop immediately, F0 follows release
        @(negedge Clock);
        check("pre_reset_f1", 1, obs, X_F1);
        #2 Reset = 1'b1;
        #1 check("async_reset", 0, obs, 21'(0));
        @(negedge Clock);
        check("reset_held", 0, obs, 21'(0));
        Reset = 1'b0;
        @(negedge Clock);
        check("f0_after_release", 0, obs, X_F0);

        run_instr(32'h00800075, 1'b0, 0, "ld", halted);
        run_instr(32'h18000000, 1'b0, 0, "add", halted);
        run_instr(32'h90000010, 1'b1, 0, "br_taken", halted);
        run_instr(32'h90000010, 1'b0, 0, "br_not_taken", halted);

        // halt: HALT absorbs for 20 cycles
        run_instr(32'hD8000000, 1'b0, 0, "halt", halted);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            check("halt_hold", i, obs, 21'(0));
        end
        do_reset();

        // nop with Stop held from F1
        run_instr(32'hF8000000, 1'b0, 1, "nop_stop", halted);
        do_reset();

        // Directed table: instruction length plus END and last execute-step strobes
        foreach (vecs[v]) begin
            int          cnt;
            logic [20:0] prev;
            logic [20:0] prev2;
            bus.IR   = vecs[v].ir;
            bus.CON  = vecs[v].con;
            bus.Stop = 1'b0;
            cnt   = 0;
            prev  = '0;
            prev2 = '0;
            while (cnt <= 20) begin
                @(negedge Clock);
                cnt++;
                if (obs == X_F0) break;
                prev2 = prev;
                prev  = obs;
            end
            check_int($sformatf("len_vec%0d", v), cnt, vecs[v].len);
            check($sformatf("end_vec%0d", v), v, prev, M_RUN);
            check($sformatf("last_exec_vec%0d", v), v, prev2, vecs[v].last_exec);
            if (cnt > 20) do_reset();
        end

        // Randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            logic [4:0]  op;
            logic [31:0] ir;
            op = ($urandom_range(0, 1) == 0) ? known_ops[$urandom_range(0, 9)] : 5'($urandom);
            ir = {op, 27'($urandom)};
            run_instr(ir, 1'($urandom), 2, $sformatf("rand%0d_op%0d", k, op), halted);
            if (halted) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge Clock);
                    check("rand_halt_hold", i, obs, 21'(0));
                end
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
